// File: rtl/arb_memory.sv
// Shared synchronous RAM with a round-robin arbiter over CHANNELS requesters.
// One access executes per cycle; reads return after one clock on the granted channel.
module arb_memory #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 256,
    parameter int CHANNELS = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CHANNELS-1:0]          req,
    input  logic [CHANNELS-1:0]          we,
    input  logic [CHANNELS*ADDR_W-1:0]   addr,
    input  logic [CHANNELS*DATA_W-1:0]   wdata,
    output logic [CHANNELS-1:0]          gnt,
    output logic [CHANNELS-1:0]          rvalid,
    output logic [CHANNELS*DATA_W-1:0]   rdata,
    output logic [CHANNELS-1:0]          err
);

    localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [PW-1:0]     ptr;
    logic [PW-1:0]     ptr_nxt;
    logic [PW-1:0]     sel;
    logic              any;
    int                idx;
    logic [ADDR_W-1:0] gaddr;
    logic              gwe;
    logic [DATA_W-1:0] gwdata;
    logic              inr;

    logic [DATA_W-1:0] mem [DEPTH];

    // Search from the pointer and wrap; first requester found wins.
    always_comb begin
        gnt     = '0;
        sel     = '0;
        any     = 1'b0;
        ptr_nxt = ptr;
        idx     = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = (int'(ptr) + k) % CHANNELS;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                sel      = PW'(idx);
                ptr_nxt  = PW'((idx + 1) % CHANNELS);
            end
        end
    end

    assign gaddr  = addr[int'(sel)*ADDR_W +: ADDR_W];
    assign gwdata = wdata[int'(sel)*DATA_W +: DATA_W];
    assign gwe    = we[sel];
    assign inr    = ({1'b0, gaddr} < (ADDR_W+1)'(DEPTH));

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (any && gwe && inr) begin
            mem[gaddr] <= gwdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= '0;
            rvalid <= '0;
            err    <= '0;
            rdata  <= '0;
        end else begin
            rvalid <= '0;
            err    <= '0;
            if (any) begin
                ptr <= ptr_nxt;
                if (!gwe) begin
                    rvalid[sel] <= 1'b1;
                    rdata[int'(sel)*DATA_W +: DATA_W] <= inr ? mem[gaddr] : '0;
                end
                if (!inr) begin
                    err[sel] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_arb_memory.sv
// Directed plus random bench for arb_memory against a round-robin memory model.
// Four channels, 200-word array so the out-of-range path is reachable.
module tb_arb_memory;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 200;
    localparam int CH    = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CH-1:0]     req;
    logic [CH-1:0]     we;
    logic [CH*AW-1:0]  addr;
    logic [CH*DW-1:0]  wdata;
    logic [CH-1:0]     gnt;
    logic [CH-1:0]     rvalid;
    logic [CH*DW-1:0]  rdata;
    logic [CH-1:0]     err;

    arb_memory #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .CHANNELS(CH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err)
    );

    always #5 clk = ~clk;

    logic [DW-1:0]    mm [256];
    int               mp;
    logic [CH-1:0]    e_rv;
    logic [CH-1:0]    e_err;
    logic [CH*DW-1:0] e_rd;
    int               vecs;
    int               bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int c, input bit w, input int a, input int d);
        req[c] = 1'b1;
        we[c]  = w;
        addr[c*AW +: AW]  = AW'(a);
        wdata[c*DW +: DW] = DW'(d);
    endtask

    // Called at a negedge with inputs already set; returns at the next negedge.
    task automatic step(input string tag, output int gc, output logic [CH-1:0] og);
        int a;
        gc = -1;
        #1;
        for (int k = 0; k < CH; k++) begin
            if (gc < 0 && req[(mp + k) % CH]) gc = (mp + k) % CH;
        end
        og = gnt;
        chk({tag, ".gnt"}, og, (gc < 0) ? 64'd0 : (64'd1 << gc));
        e_rv  = '0;
        e_err = '0;
        if (gc >= 0) begin
            a = int'(addr[gc*AW +: AW]);
            if (we[gc]) begin
                if (a < DEPTH) mm[a] = wdata[gc*DW +: DW];
            end else begin
                e_rv[gc] = 1'b1;
                e_rd[gc*DW +: DW] = (a < DEPTH) ? mm[a] : '0;
            end
            if (a >= DEPTH) e_err[gc] = 1'b1;
            mp = (gc + 1) % CH;
        end
        @(posedge clk);
        #1;
        chk({tag, ".rvalid"}, rvalid, e_rv);
        chk({tag, ".err"}, err, e_err);
        chk({tag, ".rdata"}, rdata, e_rd);
        @(negedge clk);
    endtask

    initial begin
        int gc;
        logic [CH-1:0] og;
        int waited;
        bit seen3;

        vecs  = 0;
        bad   = 0;
        mp    = 0;
        e_rd  = '0;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        chk("rst.rvalid", rvalid, 0);
        chk("rst.err", err, 0);
        chk("rst.rdata", rdata, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int a = 0; a < DEPTH; a++) begin
            drive(1, 1'b1, a, int'($urandom));
            step("init", gc, og);
            req = '0;
        end

        // single channel write then read
        drive(0, 1'b1, 'h12, 'hA5);
        step("t2.wr", gc, og);
        req = '0;
        drive(0, 1'b0, 'h12, 0);
        step("t2.rd", gc, og);
        req = '0;
        chk("t2.rdata0", rdata[7:0], 8'hA5);
        chk("t2.rvalid0", rvalid[0], 1);

        // reset mid-cycle while a read result is showing
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid.rvalid", rvalid, 0);
        chk("rstmid.err", err, 0);
        chk("rstmid.rdata", rdata, 0);
        e_rd = '0;
        mp   = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // contention between ch0 and ch1 from a freshly reset pointer
        drive(0, 1'b0, 'h10, 0);
        drive(1, 1'b0, 'h20, 0);
        for (int i = 0; i < 4; i++) begin
            step("t3", gc, og);
            chk("t3.seq", og, 64'd1 << (i % 2));
            if (gc >= 0) drive(gc, 1'b0, 'h10 + 16 * gc + i + 1, 0);
        end
        req = '0;

        // read-after-write, then ch0 result held across ch1 traffic
        drive(0, 1'b1, 'h40, 'h3C);
        step("t6.wr", gc, og);
        req = '0;
        drive(0, 1'b0, 'h40, 0);
        step("t6.rd", gc, og);
        req = '0;
        chk("t6.raw", rdata[7:0], 8'h3C);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1'b0, i * 7 + 3, 0);
            step("t6.ch1", gc, og);
            req = '0;
        end
        chk("t6.hold", rdata[7:0], 8'h3C);

        // out-of-range behaviour and the DEPTH boundary
        drive(2, 1'b0, 250, 0);
        step("t5.rd250", gc, og);
        req = '0;
        chk("t5.err2", err[2], 1);
        chk("t5.rv2", rvalid[2], 1);
        chk("t5.rd2", rdata[23:16], 0);
        drive(2, 1'b1, 250, 'hFF);
        step("t5.wr250", gc, og);
        req = '0;
        chk("t5.wr_err2", err[2], 1);
        drive(2, 1'b0, 250, 0);
        step("t5.rd250b", gc, og);
        req = '0;
        chk("t5.still0", rdata[23:16], 0);
        drive(2, 1'b0, 199, 0);
        step("t5.rd199", gc, og);
        chk("t5.ok199", err[2], 0);
        drive(2, 1'b0, 200, 0);
        step("t5.rd200", gc, og);
        chk("t5.err200", err[2], 1);
        drive(2, 1'b0, 50, 0);
        step("t5.rd50", gc, og);
        req = '0;

        // fairness: ch0 always requesting, ch3 once
        drive(0, 1'b0, 1, 0);
        drive(3, 1'b0, 2, 0);
        waited = 0;
        seen3  = 1'b0;
        for (int i = 0; i < 6 && !seen3; i++) begin
            step("t4", gc, og);
            waited++;
            if (og[3]) begin
                seen3  = 1'b1;
                req[3] = 1'b0;
            end
            if (gc == 0) drive(0, 1'b0, int'($urandom_range(0, DEPTH - 1)), 0);
        end
        chk("t4.ch3_within3", (seen3 && waited <= 3), 1);
        req = '0;

        // randomized traffic with the hold-until-granted handshake
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < CH; c++) begin
                if (!req[c] && $urandom_range(0, 1) == 1)
                    drive(c, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                          int'($urandom));
                else if (req[c] && $urandom_range(0, 15) == 0)
                    req[c] = 1'b0;
            end
            step("rnd", gc, og);
            if (gc >= 0) req[gc] = 1'b0;
        end
        req = '0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
        $finish;
    end

endmodule
